iob_cache_be_mem: RTL

IOB_CACHE_BE_MEM -- requirements
Module: iob_cache_be_mem

---
 rtl/iob_cache_be_mem_pkg.sv | 14 +
 rtl/iob_cache_be_mem_ram.sv | 31 +++
 rtl/iob_cache_be_mem.sv | 139 +++++++++++++
 3 files changed

// File: rtl/iob_cache_be_mem_pkg.sv
// Shared types and constants for the iob_cache_be_mem back-end memory model.
// FSM state encoding and latency-counter width.
package iob_cache_be_mem_pkg;

  // Wide enough to hold LATENCY-1 for LATENCY up to 8.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/iob_cache_be_mem_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Read data always reflects the address presented on the previous clock edge.
module iob_cache_be_mem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage arrays take no reset; resetting every word would turn the
  // RAM into a flop array and its contents must survive a reset anyway.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (we_i && be_i[b]) begin
        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_cache_be_mem.sv
// Back-end memory with fixed request-to-ack latency for cache testing.
// Optional access counters are enabled by defining IOB_CACHE_BE_MEM_STATS_EN.
module iob_cache_be_mem
  import iob_cache_be_mem_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o
`ifdef IOB_CACHE_BE_MEM_STATS_EN
  ,
  output logic [31:0]         rd_cnt_o,
  output logic [31:0]         wr_cnt_o
`endif
);

  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [BYTES-1:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [DATA_W-1:0]       ram_rdata;
  logic [MEM_ADDR_W-1:0]   ram_addr;
  logic                    accept, ram_we, rd_ack;
  logic                    addr_unused;

  // Aliasing above the RAM depth and sub-word offsets are intentionally dropped.
  assign addr_unused = ^{addr_i[ADDR_W-1:OFF_W+MEM_ADDR_W], addr_i[OFF_W-1:0]};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (cnt_q <= CNT_W'(1)) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && req_i;
    ack_o  = (state_q == ACK);
    ram_we = ack_o && (|wstrb_q);
    rd_ack = ack_o && !(|wstrb_q);
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (accept) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      idx_d   = addr_i[OFF_W +: MEM_ADDR_W];
      wdata_d = wdata_i;
      wstrb_d = wstrb_i;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    rdata_d = rd_ack ? ram_rdata : rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // Reading with the live address while idle lets a LATENCY=1 read have data at ack.
  assign ram_addr = (state_q == IDLE) ? addr_i[OFF_W +: MEM_ADDR_W] : idx_q;
  assign rdata_o  = rd_ack ? ram_rdata : rdata_q;

  iob_cache_be_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .be_i    (wstrb_q),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

`ifdef IOB_CACHE_BE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_ack && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
    if (ram_we && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
